// File: rtl/lfsr.sv
// Fibonacci XNOR LFSR, NUM_BITS 3..32, with seed load and return-to-seed flag.
// Define LFSR_DONE_REG_EN to register o_LFSR_Done instead of driving it combinationally.
module lfsr #(
  parameter int NUM_BITS = 4
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Enable,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  output logic [NUM_BITS-1:0] o_LFSR_Data,
  output logic                o_LFSR_Done
);

  if (NUM_BITS < 3 || NUM_BITS > 32) begin : g_bad_width
    $error("lfsr: NUM_BITS must lie in 3..32");
  end

  // One-hot mask for a 1-indexed tap position.
  function automatic logic [31:0] tap(input int unsigned k);
    return 32'h1 << (k - 1);
  endfunction

  function automatic logic [31:0] tap_mask(input int unsigned n);
    logic [31:0] m;
    m = '0;
    case (n)
      3:  m = tap(3)  | tap(2);
      4:  m = tap(4)  | tap(3);
      5:  m = tap(5)  | tap(3);
      6:  m = tap(6)  | tap(5);
      7:  m = tap(7)  | tap(6);
      8:  m = tap(8)  | tap(6)  | tap(5)  | tap(4);
      9:  m = tap(9)  | tap(5);
      10: m = tap(10) | tap(7);
      11: m = tap(11) | tap(9);
      12: m = tap(12) | tap(6)  | tap(4)  | tap(1);
      13: m = tap(13) | tap(4)  | tap(3)  | tap(1);
      14: m = tap(14) | tap(5)  | tap(3)  | tap(1);
      15: m = tap(15) | tap(14);
      16: m = tap(16) | tap(15) | tap(13) | tap(4);
      17: m = tap(17) | tap(14);
      18: m = tap(18) | tap(11);
      19: m = tap(19) | tap(6)  | tap(2)  | tap(1);
      20: m = tap(20) | tap(17);
      21: m = tap(21) | tap(19);
      22: m = tap(22) | tap(21);
      23: m = tap(23) | tap(18);
      24: m = tap(24) | tap(23) | tap(22) | tap(17);
      25: m = tap(25) | tap(22);
      26: m = tap(26) | tap(6)  | tap(2)  | tap(1);
      27: m = tap(27) | tap(5)  | tap(2)  | tap(1);
      28: m = tap(28) | tap(25);
      29: m = tap(29) | tap(27);
      30: m = tap(30) | tap(6)  | tap(4)  | tap(1);
      31: m = tap(31) | tap(28);
      32: m = tap(32) | tap(22) | tap(2)  | tap(1);
      default: m = '0;
    endcase
    return m;
  endfunction

  localparam logic [31:0]         TapsAll = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TapMask = TapsAll[NUM_BITS-1:0];

  logic [NUM_BITS-1:0] lfsr_q, lfsr_d;
  logic                feedback;
  logic                match;

  // A chain of XNORs over the taps reduces to an inverted parity, so the
  // all-zeros state feeds back a 1 and all-ones is the only self-loop.
  assign feedback = ~(^(lfsr_q & TapMask));

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    lfsr_d = lfsr_q;
    if (i_Enable) begin
      if (i_Seed_DV) lfsr_d = i_Seed_Data;
      else           lfsr_d = {lfsr_q[NUM_BITS-2:0], feedback};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) lfsr_q <= '0;
    else          lfsr_q <= lfsr_d;
  end

  assign match       = (lfsr_q == i_Seed_Data);
  assign o_LFSR_Data = lfsr_q;

`ifdef LFSR_DONE_REG_EN
  logic done_q, done_d;

  always_comb begin
    done_d = done_q;
    if (i_Enable) done_d = match;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) done_q <= 1'b0;
    else          done_q <= done_d;
  end

  assign o_LFSR_Done = done_q;
`else
  assign o_LFSR_Done = match;
`endif

endmodule

// File: tb/tb_lfsr.sv
// Directed bench for lfsr: NUM_BITS=4 vector table plus multi-cycle corner
// sequences, and parallel period sweeps for widths 3..14.
module tb_lfsr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, dv;
  logic [3:0] seed;
  logic [3:0] data;
  logic       done;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  lfsr #(.NUM_BITS(4)) u_dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_Enable    (en),
    .i_Seed_DV   (dv),
    .i_Seed_Data (seed),
    .o_LFSR_Data (data),
    .o_LFSR_Done (done)
  );

  // Period sweep: one instance per width, all seeded at 0 and running together.
  logic        sweep_rst_n = 1'b0;
  logic        sweep_en    = 1'b0;
  logic [14:3] sw_returned;
  logic [14:3] sw_seen_ones;
  int unsigned sw_period [3:14];

  for (genvar k = 3; k <= 14; k++) begin : g_sweep
    logic [k-1:0] d;
    logic         dn;
    int unsigned  edges    = 0;
    int unsigned  period   = 0;
    bit           returned = 1'b0;
    bit           seen     = 1'b0;

    lfsr #(.NUM_BITS(k)) u_lfsr (
      .i_Clk       (clk),
      .i_Rst_L     (sweep_rst_n),
      .i_Enable    (sweep_en),
      .i_Seed_DV   (1'b0),
      .i_Seed_Data ('0),
      .o_LFSR_Data (d),
      .o_LFSR_Done (dn)
    );

    always @(posedge clk) if (sweep_en) edges <= edges + 1;

    always @(negedge clk) begin
      if (sweep_en && !returned) begin
        if (d == '1) seen <= 1'b1;
        if (edges != 0 && d == '0) begin
          returned <= 1'b1;
          period   <= edges;
        end
      end
    end

    assign sw_returned[k]  = returned;
    assign sw_seen_ones[k] = seen;
    assign sw_period[k]    = period;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit       en;
    bit       dv;
    bit [3:0] seed;
    bit [3:0] exp_data;
    bit       exp_done;   // combinational-build expectation
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit e, bit d, bit [3:0] s, bit [3:0] x, bit dn);
    vec_t v;
    v.en = e; v.dv = d; v.seed = s; v.exp_data = x; v.exp_done = dn;
    return v;
  endfunction

  initial begin
    bit [3:0] cur_exp;
    bit       done_r;
    bit       exp_done;
    int       cnt;

    // Free-running sequence from reset, seed 0.
    vecs.push_back(mk(1,0,4'h0,4'h1,0)); vecs.push_back(mk(1,0,4'h0,4'h3,0));
    vecs.push_back(mk(1,0,4'h0,4'h7,0)); vecs.push_back(mk(1,0,4'h0,4'hE,0));
    vecs.push_back(mk(1,0,4'h0,4'hD,0)); vecs.push_back(mk(1,0,4'h0,4'hB,0));
    vecs.push_back(mk(1,0,4'h0,4'h6,0)); vecs.push_back(mk(1,0,4'h0,4'hC,0));
    vecs.push_back(mk(1,0,4'h0,4'h9,0)); vecs.push_back(mk(1,0,4'h0,4'h2,0));
    vecs.push_back(mk(1,0,4'h0,4'h5,0)); vecs.push_back(mk(1,0,4'h0,4'hA,0));
    vecs.push_back(mk(1,0,4'h0,4'h4,0)); vecs.push_back(mk(1,0,4'h0,4'h8,0));
    vecs.push_back(mk(1,0,4'h0,4'h0,1));
    // Load seed 6, then shift.
    vecs.push_back(mk(1,1,4'h6,4'h6,1)); vecs.push_back(mk(1,0,4'h6,4'hC,0));
    vecs.push_back(mk(1,0,4'h6,4'h9,0)); vecs.push_back(mk(1,0,4'h6,4'h2,0));
    // Hold window; seed-valid pulses must be ignored.
    vecs.push_back(mk(0,1,4'h6,4'h2,0)); vecs.push_back(mk(0,0,4'h6,4'h2,0));
    vecs.push_back(mk(0,1,4'h6,4'h2,0)); vecs.push_back(mk(0,1,4'h6,4'h2,0));
    vecs.push_back(mk(0,0,4'h6,4'h2,0));
    // Resume until the seed comes back round.
    vecs.push_back(mk(1,0,4'h6,4'h5,0)); vecs.push_back(mk(1,0,4'h6,4'hA,0));
    vecs.push_back(mk(1,0,4'h6,4'h4,0)); vecs.push_back(mk(1,0,4'h6,4'h8,0));
    vecs.push_back(mk(1,0,4'h6,4'h0,0)); vecs.push_back(mk(1,0,4'h6,4'h1,0));
    vecs.push_back(mk(1,0,4'h6,4'h3,0)); vecs.push_back(mk(1,0,4'h6,4'h7,0));
    vecs.push_back(mk(1,0,4'h6,4'hE,0)); vecs.push_back(mk(1,0,4'h6,4'hD,0));
    vecs.push_back(mk(1,0,4'h6,4'hB,0)); vecs.push_back(mk(1,0,4'h6,4'h6,1));

    rst_n = 1'b0; en = 1'b0; dv = 1'b0; seed = 4'h0;
    #12;
    check("reset_data", 32'(data), 32'h0);
`ifdef LFSR_DONE_REG_EN
    check("reset_done", 32'(done), 32'h0);
`else
    check("reset_done", 32'(done), 32'h1);
`endif
    rst_n = 1'b1;
    sweep_rst_n = 1'b1;
    sweep_en    = 1'b1;

    // Table pass. The registered build's Done is the pre-edge match, held while disabled.
    cur_exp = 4'h0;
    done_r  = 1'b0;
    foreach (vecs[i]) begin
      en = vecs[i].en; dv = vecs[i].dv; seed = vecs[i].seed;
`ifdef LFSR_DONE_REG_EN
      if (vecs[i].en) done_r = (cur_exp == vecs[i].seed);
      exp_done = done_r;
`else
      exp_done = vecs[i].exp_done;
`endif
      step();
      check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(exp_done));
      cur_exp = vecs[i].exp_data;
    end

    // Done recurs every 15 enabled edges with the seed held at 6.
    en = 1'b1; dv = 1'b0; seed = 4'h6;
`ifdef LFSR_DONE_REG_EN
    step();
`endif
    check("period_done_start", 32'(done), 32'h1);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!done && cnt < 40);
    check("done_period", 32'(cnt), 32'd15);
`ifdef LFSR_DONE_REG_EN
    check("done_period_data", 32'(data), 32'hC);
`else
    check("done_period_data", 32'(data), 32'h6);
    // Done follows a seed change with no clock edge.
    en = 1'b0;
    seed = 4'h3; #1;
    check("seed_change_low", 32'(done), 32'h0);
    seed = 4'h6; #1;
    check("seed_change_high", 32'(done), 32'h1);
`endif

    // Asynchronous reset between edges at data=B.
    en = 1'b1; dv = 1'b1; seed = 4'hB;
    step();
    check("load_B", 32'(data), 32'hB);
    dv = 1'b0; seed = 4'h6;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_data", 32'(data), 32'h0);
    check("async_rst_done", 32'(done), 32'h0);
    step();
    check("rst_held_data", 32'(data), 32'h0);
    #2;
    rst_n = 1'b1;
    step();
    check("post_rst_first", 32'(data), 32'h1);

    // All-ones seed locks up.
    dv = 1'b1; seed = 4'hF;
    step();
    dv = 1'b0;
    repeat (3) step();
    check("lockup_data", 32'(data), 32'hF);
    check("lockup_done", 32'(done), 32'h1);
    en = 1'b0;

    // Period sweep results.
    cnt = 0;
    while (sw_returned != '1 && cnt < 20000) begin
      @(negedge clk);
      cnt++;
    end
    check("sweep_all_returned", 32'(sw_returned), 32'hFFF);
    for (int k = 3; k <= 14; k++) begin
      check($sformatf("period_w%0d", k), sw_period[k], (32'd1 << k) - 32'd1);
      check($sformatf("no_ones_w%0d", k), 32'(sw_seen_ones[k]), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
